// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM with clear sequencer.
package ram_pkg;

  // Clear sequencer FSM states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Same-address read/write collision behaviour
  localparam int RD_OLD = 0;  // read returns pre-write contents
  localparam int RD_NEW = 1;  // read returns the data being written

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: owns the IDLE/CLEAR FSM, the clear counter and busy,
// and drives the single write mux into the storage array.
// Build option: RAM_AUTO_CLEAR_EN makes reset enter CLEAR so the array is
// zeroed automatically after every reset.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] din,
  output logic          busy,
  output logic          mem_we,
  output logic [AW-1:0] mem_wa,
  output logic [DW-1:0] mem_din
);

  localparam int DEPTH = 1 << AW;
  // One extra bit so the terminal-count compare never relies on wrap-around
  localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

  state_t      state_reg;
  logic [AW:0] cnt_reg;
  logic        busy_reg;

  // FSM, clear counter and registered busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef RAM_AUTO_CLEAR_EN
      state_reg <= ST_CLEAR;
      busy_reg  <= 1'b1;
`else
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
`endif
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (clr_req) begin
            state_reg <= ST_CLEAR;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt_reg == LAST_ADDR) begin
            // clr_req is only looked at on the final clear cycle
            cnt_reg <= '0;
            if (!clr_req) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Write mux: clear writes own the port while busy, user writes otherwise
  always_comb begin
    mem_we  = busy_reg ? 1'b1 : we;
    mem_wa  = busy_reg ? cnt_reg[AW-1:0] : wa;
    mem_din = busy_reg ? '0 : din;
  end

  assign busy = busy_reg;

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM (one write, one registered read port) with a
// whole-array clear sequence.
// Build option: RAM_AUTO_CLEAR_EN (see ram_clr_seq) clears after reset.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int AW      = 6,
  parameter int DW      = 8,
  parameter int RD_MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] din,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          clr_req,
  output logic          busy
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] dout_reg;
  logic          dout_valid_reg;

  ram_clr_seq #(
    .AW (AW),
    .DW (DW)
  ) u_clr_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .we      (we),
    .wa      (wa),
    .din     (din),
    .busy    (busy),
    .mem_we  (mem_we),
    .mem_wa  (mem_wa),
    .mem_din (mem_din)
  );

  // Array write port; contents are deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_din;
    end
  end

  // Registered read with optional write-through on address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else if (re && !busy) begin
      if (RD_MODE == RD_NEW && we && (wa == ra)) begin
        dout_reg <= din;
      end else begin
        dout_reg <= mem[ra];
      end
      dout_valid_reg <= 1'b1;
    end else begin
      dout_valid_reg <= 1'b0;
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr: two instances (read-old and
// write-through) share all inputs and are compared against an array model.
module tb_ram_dp_clr;

`ifdef RAM_AUTO_CLEAR_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] din = '0;
  logic          re = 1'b0;
  logic [AW-1:0] ra = '0;
  logic          clr_req = 1'b0;
  logic [DW-1:0] dout0, dout1;
  logic          dv0, dv1, busy0, busy1;

  always #5 clk = ~clk;

  ram_dp_clr #(.AW(AW), .DW(DW), .RD_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .din(din), .re(re), .ra(ra),
    .dout(dout0), .dout_valid(dv0), .clr_req(clr_req), .busy(busy0));

  ram_dp_clr #(.AW(AW), .DW(DW), .RD_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .din(din), .re(re), .ra(ra),
    .dout(dout1), .dout_valid(dv1), .clr_req(clr_req), .busy(busy1));

  // Reference model
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  int            clr_left;
  logic [DW-1:0] exp0, exp1;
  bit            k0, k1, exp_valid;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".busy0"}, 32'(busy0), 32'(clr_left > 0));
    check({tag, ".busy1"}, 32'(busy1), 32'(clr_left > 0));
    check({tag, ".dv0"}, 32'(dv0), 32'(exp_valid));
    check({tag, ".dv1"}, 32'(dv1), 32'(exp_valid));
    if (k0) check({tag, ".dout0"}, 32'(dout0), 32'(exp0));
    if (k1) check({tag, ".dout1"}, 32'(dout1), 32'(exp1));
  endtask

  // One clock: drive inputs, advance the model at the edge, then check.
  task automatic step(input bit s_we, input int s_wa, input int s_din,
                      input bit s_re, input int s_ra, input bit s_clr, input string tag);
    bit was_busy;
    we = s_we; wa = AW'(s_wa); din = DW'(s_din);
    re = s_re; ra = AW'(s_ra); clr_req = s_clr;
    @(posedge clk);
    was_busy = (clr_left > 0);
    if (was_busy) begin
      m_mem[DEPTH - clr_left] = '0;
      m_known[DEPTH - clr_left] = 1'b1;
      clr_left--;
      if (clr_left == 0 && s_clr) clr_left = DEPTH;
      exp_valid = 1'b0;
    end else begin
      if (s_re) begin
        exp_valid = 1'b1;
        exp0 = m_mem[s_ra];
        k0 = m_known[s_ra];
        if (s_we && s_wa == s_ra) begin
          exp1 = DW'(s_din);
          k1 = 1'b1;
        end else begin
          exp1 = m_mem[s_ra];
          k1 = m_known[s_ra];
        end
      end else begin
        exp_valid = 1'b0;
      end
      if (s_we) begin
        m_mem[s_wa] = DW'(s_din);
        m_known[s_wa] = 1'b1;
      end
      if (s_clr) clr_left = DEPTH;
    end
    #1;
    $display("step %-10s we=%0d wa=%0d din=%02h re=%0d ra=%0d clr=%0d | busy=%0d dv=%0d dout0=%02h dout1=%02h",
             tag, s_we, s_wa, s_din, s_re, s_ra, s_clr, busy0, dv0, dout0, dout1);
    check_outputs(tag);
  endtask

  task automatic idle_until_free(input string tag);
    int guard;
    guard = 0;
    while (clr_left > 0 && guard < 300) begin
      step(0, 0, 0, 0, 0, 0, tag);
      guard++;
    end
    check({tag, ".timeout"}, 32'(clr_left > 0), 32'(0));
  endtask

  initial begin
    int busy_cycles;
    int guard;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_known[i] = 1'b0;
    end
    clr_left = 0;
    exp0 = '0; exp1 = '0; k0 = 1'b1; k1 = 1'b1; exp_valid = 1'b0;

    // Reset state
    #12;
    check("rst.dout0", 32'(dout0), 32'(0));
    check("rst.dout1", 32'(dout1), 32'(0));
    check("rst.dv0", 32'(dv0), 32'(0));
    check("rst.busy0", 32'(busy0), 32'(AUTO));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    clr_left = AUTO ? DEPTH : 0;
    #3;
    idle_until_free("rstclr");
    if (AUTO) begin
      for (int i = 0; i < DEPTH; i++) begin
        check("auto.zero", 32'(m_known[i]), 32'(1));
      end
    end

    // Write then read next cycle
    step(1, 3, 8'hA5, 0, 0, 0, "wr3");
    step(0, 0, 0, 1, 3, 0, "rd3");
    step(0, 0, 0, 0, 0, 0, "rd3.hold");

    // Same-address collision
    step(1, 9, 8'h11, 0, 0, 0, "wr9");
    step(1, 9, 8'h22, 1, 9, 0, "coll9");
    step(0, 0, 0, 1, 9, 0, "rd9");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 255),
           1'($urandom_range(0, 1)), $urandom_range(0, 63), 0, "rand");
    end

    // Fill with FF, pulse clear, inject ignored traffic mid-clear
    for (int i = 0; i < DEPTH; i++) step(1, i, 8'hFF, 0, 0, 0, "fill");
    step(0, 0, 0, 1, 40, 0, "rd40");
    step(0, 0, 0, 0, 0, 1, "clrpulse");
    busy_cycles = 0;
    guard = 0;
    while (busy0 === 1'b1 && guard < 200) begin
      busy_cycles++;
      if (busy_cycles == 10) step(1, 5, 8'h77, 1, 5, 1'b0, "clrinject");
      else step(0, 0, 0, 0, 0, 0, "clearing");
      guard++;
    end
    check("clr.busylen", 32'(busy_cycles), 32'(DEPTH));
    step(0, 0, 0, 1, 0, 0, "rd0");
    step(0, 0, 0, 1, 31, 0, "rd31");
    step(0, 0, 0, 1, 63, 0, "rd63");
    step(0, 0, 0, 1, 5, 0, "rd5");
    check("clr.mem5", 32'(dout0), 32'(0));

    // Reset during clear at cycle 20
    for (int i = 0; i < DEPTH; i++) step(1, i, 8'hFF, 0, 0, 0, "fill2");
    step(0, 0, 0, 1, 40, 0, "rd40b");
    step(0, 0, 0, 0, 0, 1, "clrpulse2");
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, "clearing2");
    #2 rst_n = 1'b0;
    #1;
    check("arst.dout0", 32'(dout0), 32'(0));
    check("arst.dout1", 32'(dout1), 32'(0));
    check("arst.dv0", 32'(dv0), 32'(0));
    check("arst.busy", 32'(busy0), 32'(AUTO));
    exp0 = '0; exp1 = '0; k0 = 1'b1; k1 = 1'b1; exp_valid = 1'b0;
    clr_left = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    clr_left = AUTO ? DEPTH : 0;
    #1;
    check("arst.rel.busy", 32'(busy0), 32'(AUTO));
    busy_cycles = 0;
    while (clr_left > 0 && busy_cycles < 200) begin
      step(0, 0, 0, 0, 0, 0, "reclear");
      busy_cycles++;
    end
    check("arst.busylen", 32'(busy_cycles), 32'(AUTO ? DEPTH : 0));
    for (int i = 0; i < 26; i++) step(0, 0, 0, 1, i, 0, "rdpost");

    // Continuous clr_req: back-to-back clears
    step(0, 0, 0, 0, 0, 1, "hold.start");
    for (int i = 0; i < 3 * DEPTH; i++) step(1, 7, 8'h5A, 1, 7, 1, "hold");
    step(0, 0, 0, 0, 0, 0, "hold.drop");
    idle_until_free("hold.tail");
    step(0, 0, 0, 1, 7, 0, "rd7");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
